// File: rtl/arch_map.sv
// Architectural (committed) register map.
// Purpose: holds the retirement-side rename map. Retiring slots update the map and
//   release the previous physical tag (Told) to the free list one cycle later. A
//   mispredicted branch at retire freezes the map and presents it as a recovery
//   snapshot until the front end accepts it.
// Ports:
//   clock, reset                 - single clock, synchronous active-high reset
//   ret_valid/dest/new/old_tag   - RET_W retire slots, slot 0 oldest
//   recover_req, recover_ready   - recovery request at retire / front-end accept
//   fl_free_valid, fl_free_tag   - registered Told release per slot
//   recover_valid, recover_map   - snapshot handshake and full committed map
//   ret_stall                    - holds retire while a snapshot is pending
//   map_err                      - sticky Told-consistency error
//   retired_count                - wrapping count of retired instructions
module arch_map #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned RET_W     = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [RET_W-1:0]           ret_valid,
  input  logic [RET_W*5-1:0]         ret_dest_reg,
  input  logic [RET_W*TAG_W-1:0]     ret_new_tag,
  input  logic [RET_W*TAG_W-1:0]     ret_old_tag,
  input  logic                       recover_req,
  input  logic                       recover_ready,
  output logic [RET_W-1:0]           fl_free_valid,
  output logic [RET_W*TAG_W-1:0]     fl_free_tag,
  output logic                       recover_valid,
  output logic [ARCH_REGS*TAG_W-1:0] recover_map,
  output logic                       ret_stall,
  output logic                       map_err,
  output logic [31:0]                retired_count
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StRecover = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] amap_q [ARCH_REGS];
  logic [TAG_W-1:0] amap_d [ARCH_REGS];

  logic [4:0]             dest    [RET_W];
  logic [TAG_W-1:0]       new_tag [RET_W];
  logic [TAG_W-1:0]       old_tag [RET_W];
  logic [RET_W-1:0]       accept;
  logic [RET_W-1:0]       free_valid_d;
  logic [RET_W*TAG_W-1:0] free_tag_d;
  logic                   err_d;
  logic [31:0]            acc_cnt;

  always_comb begin
    for (int k = 0; k < RET_W; k++) begin
      dest[k]    = ret_dest_reg[k*5 +: 5];
      new_tag[k] = ret_new_tag[k*TAG_W +: TAG_W];
      old_tag[k] = ret_old_tag[k*TAG_W +: TAG_W];
      accept[k]  = ret_valid[k] && (state_q == StIdle);
    end
  end

  // Slots are applied oldest first, so amap_d[dest] seen by slot k already
  // reflects any older same-cycle slot; that is exactly the expected Told.
  always_comb begin
    amap_d       = amap_q;
    err_d        = 1'b0;
    acc_cnt      = '0;
    free_valid_d = '0;
    free_tag_d   = fl_free_tag;
    for (int k = 0; k < RET_W; k++) begin
      if (accept[k]) begin
        acc_cnt = acc_cnt + 32'd1;
        if (dest[k] != 5'd0) begin
          if (amap_d[dest[k]] != old_tag[k]) begin
            err_d = 1'b1;
          end
          amap_d[dest[k]]                 = new_tag[k];
          free_valid_d[k]                 = 1'b1;
          free_tag_d[k*TAG_W +: TAG_W]    = old_tag[k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (recover_req && (|accept)) state_d = StRecover;
      StRecover: if (recover_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        amap_q[i] <= TAG_W'(i);
      end
      state_q       <= StIdle;
      fl_free_valid <= '0;
      fl_free_tag   <= '0;
      map_err       <= 1'b0;
      retired_count <= '0;
    end else begin
      amap_q        <= amap_d;
      state_q       <= state_d;
      fl_free_valid <= free_valid_d;
      fl_free_tag   <= free_tag_d;
      map_err       <= map_err | err_d;
      retired_count <= retired_count + acc_cnt;
    end
  end

  // No slot is accepted in RECOVER, so the live map is the held snapshot.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      recover_map[i*TAG_W +: TAG_W] = amap_q[i];
    end
  end

  assign recover_valid = (state_q == StRecover);
  assign ret_stall     = (state_q == StRecover);

endmodule

// File: tb/tb_arch_map.sv
module tb_arch_map;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   ret_valid;
  logic [9:0]   ret_dest_reg;
  logic [11:0]  ret_new_tag;
  logic [11:0]  ret_old_tag;
  logic         recover_req;
  logic         recover_ready;
  logic [1:0]   fl_free_valid;
  logic [11:0]  fl_free_tag;
  logic         recover_valid;
  logic [191:0] recover_map;
  logic         ret_stall;
  logic         map_err;
  logic [31:0]  retired_count;

  always #5 clock = ~clock;

  arch_map dut (
    .clock         (clock),
    .reset         (reset),
    .ret_valid     (ret_valid),
    .ret_dest_reg  (ret_dest_reg),
    .ret_new_tag   (ret_new_tag),
    .ret_old_tag   (ret_old_tag),
    .recover_req   (recover_req),
    .recover_ready (recover_ready),
    .fl_free_valid (fl_free_valid),
    .fl_free_tag   (fl_free_tag),
    .recover_valid (recover_valid),
    .recover_map   (recover_map),
    .ret_stall     (ret_stall),
    .map_err       (map_err),
    .retired_count (retired_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle
  bit [1:0] s_v;
  int       s_d [2];
  int       s_t [2];
  int       s_o [2];
  bit       s_req, s_rdy, s_rst;

  // Reference model: committed map, recovery flag, sticky error, counters
  int          m_amap [32];
  bit          m_rec;
  bit          m_err;
  bit [31:0]   m_cnt;
  bit [1:0]    m_fv;
  int          m_ft [2];

  task automatic model_step();
    bit a0, a1;
    int e0, e1;
    if (s_rst) begin
      for (int i = 0; i < 32; i++) m_amap[i] = i;
      m_rec = 0; m_err = 0; m_cnt = 0; m_fv = 0;
      return;
    end
    a0 = s_v[0] && !m_rec;
    a1 = s_v[1] && !m_rec;
    e0 = m_amap[s_d[0]];
    e1 = (a0 && a1 && s_d[1] == s_d[0] && s_d[0] != 0) ? s_t[0] : m_amap[s_d[1]];
    if (a0 && s_d[0] != 0 && s_o[0] != e0) m_err = 1;
    if (a1 && s_d[1] != 0 && s_o[1] != e1) m_err = 1;
    m_fv[0] = a0 && s_d[0] != 0;
    m_fv[1] = a1 && s_d[1] != 0;
    m_ft[0] = s_o[0];
    m_ft[1] = s_o[1];
    if (a0 && s_d[0] != 0) m_amap[s_d[0]] = s_t[0];
    if (a1 && s_d[1] != 0) m_amap[s_d[1]] = s_t[1];
    m_cnt = m_cnt + 32'(a0) + 32'(a1);
    if (m_rec) begin
      if (s_rdy) m_rec = 0;
    end else if (s_req && (a0 || a1)) begin
      m_rec = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("free_valid", fl_free_valid, m_fv);
    for (int k = 0; k < 2; k++)
      if (m_fv[k]) check_eq($sformatf("free_tag%0d", k), fl_free_tag[k*6 +: 6], m_ft[k]);
    check_eq("recover_valid", recover_valid, m_rec);
    check_eq("ret_stall", ret_stall, m_rec);
    check_eq("map_err", map_err, m_err);
    check_eq("retired_count", retired_count, m_cnt);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("rmap[%0d]", i), recover_map[i*6 +: 6], m_amap[i]);
  endtask

  task automatic cycle();
    reset         = s_rst;
    ret_valid     = s_v;
    ret_dest_reg  = {5'(s_d[1]), 5'(s_d[0])};
    ret_new_tag   = {6'(s_t[1]), 6'(s_t[0])};
    ret_old_tag   = {6'(s_o[1]), 6'(s_o[0])};
    recover_req   = s_req;
    recover_ready = s_rdy;
    #1;
    if (!s_rst) check_eq("ret_stall_comb", ret_stall, m_rec);
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle_stim();
    s_v = 0; s_req = 0; s_rdy = 0; s_rst = 0;
    for (int k = 0; k < 2; k++) begin s_d[k] = 0; s_t[k] = 0; s_o[k] = 0; end
  endtask

  task automatic do_reset();
    idle_stim(); s_rst = 1; cycle(); s_rst = 0;
  endtask

  initial begin
    m_rec = 0; m_err = 0; m_cnt = 0; m_fv = 0;
    @(posedge clock); #1;
    do_reset();
    idle_stim(); cycle();
    check_eq("rst_count", retired_count, 0);
    check_eq("rst_stall", ret_stall, 0);

    // Single retire, dest 3
    s_v = 2'b01; s_d[0] = 3; s_t[0] = 40; s_o[0] = 3; cycle();
    check_eq("d3_free_valid", fl_free_valid, 2'b01);
    check_eq("d3_free_tag", fl_free_tag[5:0], 3);
    check_eq("d3_map", recover_map[3*6 +: 6], 40);
    check_eq("d3_count", retired_count, 1);
    idle_stim(); cycle();

    // Dual retire to the same dest: consistent, then inconsistent Told
    s_v = 2'b11; s_d[0] = 5; s_t[0] = 41; s_o[0] = 5; s_d[1] = 5; s_t[1] = 42; s_o[1] = 41;
    cycle();
    check_eq("dual_map", recover_map[5*6 +: 6], 42);
    check_eq("dual_err0", map_err, 0);
    check_eq("dual_frees", fl_free_tag, {6'd41, 6'd5});
    s_t[0] = 43; s_o[0] = 42; s_t[1] = 44; s_o[1] = 5; cycle();
    check_eq("dual_err1", map_err, 1);
    idle_stim(); cycle();
    check_eq("err_sticky", map_err, 1);
    do_reset();

    // Dest 0 retire
    s_v = 2'b01; s_d[0] = 0; s_t[0] = 50; cycle();
    check_eq("d0_free_valid", fl_free_valid, 0);
    check_eq("d0_map", recover_map[5:0], 0);
    check_eq("d0_count", retired_count, 1);

    // Recovery with ready held low for three cycles
    idle_stim(); s_v = 2'b01; s_d[0] = 7; s_t[0] = 44; s_o[0] = 7; s_req = 1; cycle();
    for (int c = 0; c < 3; c++) begin
      s_req = 0; s_v = 2'b11; s_d[0] = 7; s_t[0] = 9; s_o[0] = 44; s_d[1] = 8; s_t[1] = 10;
      s_o[1] = 8; cycle();
      check_eq("rec_hold_valid", recover_valid, 1);
      check_eq("rec_hold_map", recover_map[7*6 +: 6], 44);
    end
    idle_stim(); s_rdy = 1; cycle();
    check_eq("rec_exit", recover_valid, 0);
    check_eq("rec_count", retired_count, 2);

    // Reset while in recovery
    idle_stim(); s_v = 2'b01; s_d[0] = 9; s_t[0] = 60; s_o[0] = 9; s_req = 1; cycle();
    check_eq("rec2_enter", ret_stall, 1);
    do_reset();
    check_eq("rec2_rst_valid", recover_valid, 0);
    check_eq("rec2_rst_map", recover_map[9*6 +: 6], 9);
    check_eq("rec2_rst_count", retired_count, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle_stim();
      s_rst = ($urandom_range(59) == 0);
      s_v   = 2'($urandom_range(3));
      s_d[0] = $urandom_range(31);
      s_d[1] = ($urandom_range(3) == 0) ? s_d[0] : $urandom_range(31);
      s_t[0] = $urandom_range(63);
      s_t[1] = $urandom_range(63);
      s_o[0] = m_amap[s_d[0]];
      s_o[1] = (s_v == 2'b11 && !m_rec && s_d[1] == s_d[0] && s_d[0] != 0) ? s_t[0]
                                                                            : m_amap[s_d[1]];
      for (int k = 0; k < 2; k++)
        if ($urandom_range(9) == 0) s_o[k] = s_o[k] ^ $urandom_range(63, 1);
      s_req = ($urandom_range(5) == 0);
      s_rdy = ($urandom_range(2) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arch_map.md
ARCH_MAP -- requirements
Module: arch_map

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter TAG_W, default 6, physical tag width (64 physical registers).
REQ-003 SHALL have parameter RET_W, default 2, retire slots per cycle; slot 0 is oldest.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ret_valid  input  RET_W  retire slot k carries a retiring instruction.
REQ-007 ret_dest_reg  input  RET_W*5  architectural destination of slot k.
REQ-008 ret_new_tag  input  RET_W*TAG_W  physical tag T allocated to slot k at dispatch.
REQ-009 ret_old_tag  input  RET_W*TAG_W  previous mapping Told of slot k's destination.
REQ-010 recover_req  input  1  a retiring slot this cycle is a mispredicted branch.
REQ-011 recover_ready  input  1  front-end map table accepts the snapshot.
REQ-012 fl_free_valid  output  RET_W  Told of slot k is released to the free list.
REQ-013 fl_free_tag  output  RET_W*TAG_W  released tag per slot.
REQ-014 recover_valid  output  1  recover_map is valid and held.
REQ-015 recover_map  output  ARCH_REGS*TAG_W  full committed map snapshot.
REQ-016 ret_stall  output  1  retire must hold; drives the ROB retire stall.
REQ-017 map_err  output  1  sticky Told-consistency error flag.
REQ-018 retired_count  output  32  running count of retired instructions.

Function
REQ-019 SHALL hold amap[ARCH_REGS] of TAG_W-bit committed mappings.
REQ-020 Slot k SHALL be accepted when ret_valid[k]=1 and FSM is IDLE; all slots SHALL be ignored in RECOVER.
REQ-021 Accepted slot with dest!=0 SHALL write amap[dest]<=ret_new_tag at the next edge.
REQ-022 Same dest in both slots SHALL leave slot 1's (younger) tag in amap.
REQ-023 Dest 0 SHALL never write amap[0] and SHALL never release a tag.
REQ-024 fl_free_valid[k]/fl_free_tag[k] SHALL be registered: one cycle after acceptance, valid=1 and tag=ret_old_tag[k] for dest!=0; otherwise valid=0.
REQ-025 Expected Told: slot 0 = amap[dest0]; slot 1 = ret_new_tag[0] if dest1==dest0 (both accepted, dest!=0), else amap[dest1]; any mismatch SHALL set map_err at the next edge; map_err stays set until reset.
REQ-026 retired_count SHALL add the number of accepted slots (dest 0 included) each cycle and wrap modulo 2^32.
REQ-027 FSM states: IDLE, RECOVER.
REQ-028 IDLE with recover_req=1 and at least one accepted slot: same-cycle retire writes SHALL apply, recover_map SHALL be loaded with the updated amap, and the FSM SHALL go to RECOVER.
REQ-029 recover_req without any ret_valid SHALL be ignored.
REQ-030 RECOVER: recover_valid=1 and recover_map SHALL be held stable until recover_ready=1, then return to IDLE at the next edge.
REQ-031 ret_stall SHALL be combinational and equal (state==RECOVER).
REQ-032 The first retire is accepted the cycle after the recover_ready handshake.
REQ-033 recover_ready in IDLE SHALL be ignored.
REQ-034 recover_map SHALL equal amap whenever in IDLE.

Reset
REQ-035 reset SHALL set amap[i]=i for all i, state=IDLE, and clear fl_free_valid, recover_valid, map_err and retired_count.
REQ-036 reset SHALL take priority over all other inputs, including mid-RECOVER (abandon to IDLE, identity map).
REQ-037 Inputs SHALL be ignored in the reset cycle.

Verification
REQ-038 Reset, no traffic -> recover_map entry i = i, all outputs 0, ret_stall=0.
REQ-039 Slot0 retire dest=3 T=40 Told=3 -> next cycle fl_free_valid=01, fl_free_tag[0]=3, amap[3]=40, retired_count=1, map_err=0.
REQ-040 Dual retire, both dest=5: slot0 T=41 Told=5, slot1 T=42 Told=41 -> amap[5]=42, frees 5 and 41, map_err=0; repeat with slot1 Told=5 -> map_err=1.
REQ-041 Slot0 dest=0 T=50 -> no amap change, fl_free_valid=0, retired_count+1.
REQ-042 recover_req with slot0 dest=7 T=44 Told=7, recover_ready held 0 for 3 cycles -> recover_valid=1 and ret_stall=1 for 4 cycles, recover_map[7]=44, retires offered meanwhile are ignored; ready=1 -> IDLE next cycle.
REQ-043 reset asserted during RECOVER -> next cycle IDLE, identity map, recover_valid=0, retired_count=0.
